// File: rtl/ssd_pkg.sv
// Shared glyph table, segment constants and converter state encoding for the
// multiplexed seven-segment display controller.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ssd_bin2bcd_seq.sv
// Sequential binary-to-digit converter: one-bit-per-cycle double-dabble in
// decimal mode, direct nibble split in hex mode; flags values that do not fit.
module ssd_bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int BIN_W    = 11,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  hex,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] digits,
  output logic                  ovf
);

  localparam int DW  = 4 * N_DIGITS;
  localparam int BW  = DW + 4;
  localparam int CNW = $clog2(BIN_W + 1);

  conv_state_t            state, state_nxt;
  logic [BIN_W-1:0]       sr;
  logic [BW-1:0]          bcd, adj;
  logic [BIN_W+DW-1:0]    ext;
  logic [CNW-1:0]         cnt;
  logic                   stk, hx, last;

  assign last = hx || (cnt == CNW'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CONV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:  if (start) state_nxt = CONV_SHIFT;
      CONV_SHIFT: if (last)  state_nxt = CONV_DONE;
      CONV_DONE:  state_nxt = CONV_IDLE;
      default:    state_nxt = CONV_IDLE;
    endcase
  end

  // Add-3 on every nibble, including the spare top digit, before each shift.
  always_comb begin
    adj = bcd;
    for (int k = 0; k <= N_DIGITS; k++)
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      bcd <= '0;
      stk <= 1'b0;
      hx  <= 1'b0;
      cnt <= '0;
    end else if (state == CONV_IDLE && start) begin
      sr  <= bin;
      hx  <= hex;
      bcd <= '0;
      stk <= 1'b0;
      cnt <= '0;
    end else if (state == CONV_SHIFT && !hx) begin
      bcd <= {adj[BW-2:0], sr[BIN_W-1]};
      stk <= stk | adj[BW-1];   // any bit pushed past the spare digit is overflow
      sr  <= sr << 1;
      cnt <= cnt + CNW'(1);
    end
  end

  assign ext    = {{DW{1'b0}}, sr};
  assign done   = (state == CONV_DONE);
  assign digits = hx ? ext[DW-1:0] : bcd[DW-1:0];
  assign ovf    = hx ? |ext[BIN_W+DW-1:DW] : (stk | (|bcd[BW-1:DW]));

endmodule

// File: rtl/ssd_mux_ctrl.sv
// Multiplexed common-anode display driver: scans N_DIGITS digits, converting
// the value sampled at each frame start and showing it on the following frame.
module ssd_mux_ctrl
  import ssd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 11,
  parameter int DIV      = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIN_W-1:0]    din,
  input  logic                hex_mode,
  input  logic                blank_lz,
  input  logic [N_DIGITS-1:0] dp_in,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                ovf
);

  localparam int CW  = $clog2(DIV);
  localparam int DXW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  if (DIV <= BIN_W + 2) begin : g_bad_div
    $error("ssd_mux_ctrl: DIV must exceed BIN_W+2");
  end

  logic [CW-1:0]                 cnt;
  logic [DXW-1:0]                d, d_next;
  logic                          tick, d_last, frame_tick;

  logic                          cap_blz;
  logic [N_DIGITS-1:0]           cap_dp;

  logic                          conv_done, conv_ovf;
  logic [4*N_DIGITS-1:0]         conv_dig;

  logic [N_DIGITS-1:0][3:0]      pend_dig, disp_dig, src_dig;
  logic [N_DIGITS-1:0]           pend_dp, disp_dp, src_dp;
  logic                          pend_ovf, disp_ovf, src_ovf;
  logic                          pend_blz, disp_blz, src_blz;

  logic [N_DIGITS-1:0]           lz, an_nxt;
  logic [6:0]                    seg_nxt;
  logic                          dp_nxt, seen;

  assign tick       = (cnt == CW'(DIV - 1));
  assign d_last     = (d == DXW'(N_DIGITS - 1));
  assign frame_tick = tick & d_last;
  assign d_next     = d_last ? '0 : d + DXW'(1);

  ssd_bin2bcd_seq #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (frame_tick),
    .bin    (din),
    .hex    (hex_mode),
    .done   (conv_done),
    .digits (conv_dig),
    .ovf    (conv_ovf)
  );

  // Digit 0 of a new frame must already see the buffer committed on this tick.
  always_comb begin
    src_dig = frame_tick ? pend_dig : disp_dig;
    src_dp  = frame_tick ? pend_dp  : disp_dp;
    src_ovf = frame_tick ? pend_ovf : disp_ovf;
    src_blz = frame_tick ? pend_blz : disp_blz;

    seen = 1'b0;
    lz   = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      seen  = seen | (src_dig[i] != 4'd0);
      lz[i] = src_blz & ~seen;
    end

    an_nxt         = '1;
    an_nxt[d_next] = 1'b0;
    if (src_ovf)          seg_nxt = SEG_DASH;
    else if (lz[d_next])  seg_nxt = SEG_BLANK;
    else                  seg_nxt = seg_glyph(src_dig[d_next]);
    dp_nxt = src_ovf | ~src_dp[d_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      d   <= DXW'(N_DIGITS - 1);
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      ovf <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        d   <= d_next;
        an  <= an_nxt;
        seg <= seg_nxt;
        dp  <= dp_nxt;
      end
      if (frame_tick) ovf <= pend_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_blz  <= 1'b0;
      cap_dp   <= '0;
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_ovf <= 1'b0;
      pend_blz <= 1'b0;
      disp_dig <= '0;
      disp_dp  <= '0;
      disp_ovf <= 1'b0;
      disp_blz <= 1'b0;
    end else begin
      if (frame_tick) begin
        cap_blz  <= blank_lz;
        cap_dp   <= dp_in;
        disp_dig <= pend_dig;
        disp_dp  <= pend_dp;
        disp_ovf <= pend_ovf;
        disp_blz <= pend_blz;
      end
      if (conv_done) begin
        pend_dig <= conv_dig;
        pend_dp  <= cap_dp;
        pend_ovf <= conv_ovf;
        pend_blz <= cap_blz;
      end
    end
  end

endmodule

// File: doc/ssd_mux_ctrl.md
# ssd_mux_ctrl

Parametrised multiplexed seven-segment display controller: the generalised successor of the team's fixed 4-digit, 11-bit display driver. It takes an unsigned binary value and shows it on `N_DIGITS` common-anode digits. Display is in decimal (sequential double-dabble) or hexadecimal, with optional leading-zero blanking, per-digit decimal points and overflow indication. Display updates are frame-coherent: the value on the display never tears mid-scan. It sits between the debug/status logic and the board's SSD pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned, ≥1.
- `BIN_W`, 11: width of `DIN`, ≥1.
- `DIV`, 50000: `CLK` cycles per digit slot; must exceed `BIN_W+2` (elaboration assertion).
- `CLK`  in  1  system clock, 100 MHz.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `DIN`  in  `BIN_W`  unsigned value to display.
- `HEX_MODE`  in  1  1 = hexadecimal, 0 = decimal; sampled with `DIN`.
- `BLANK_LZ`  in  1  1 = blank leading zeros; sampled with `DIN`.
- `DP_IN`  in  `N_DIGITS`  decimal-point enables, bit i = digit i (digit 0 = least significant); sampled with `DIN`.
- `AN`  out  `N_DIGITS`  anodes, active-low, one-hot-low while scanning.
- `SEG`  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- `DP`  out  1  decimal-point cathode, active-low.
- `OVF`  out  1  high while the displayed frame is an overflow frame.

## Operation
- **Slot counter** counts 0..`DIV`-1 and wraps. `tick` is high for one cycle when the count equals `DIV`-1.
- **Digit index** `d` advances on each `tick` as 0→1→…→`N_DIGITS`-1→0. A tick that takes `d` to 0 is a *frame tick*.
- **Frame tick actions**, all in the same cycle:
  - (a) Commit the pending result (digits, overflow flag, DP mask) into the display buffer.
  - (b) Capture `DIN`, `HEX_MODE`, `BLANK_LZ` and `DP_IN`, then start a conversion.
- **Converter FSM** has states IDLE → SHIFT → DONE → IDLE.
  - Hex mode: SHIFT lasts 1 cycle; digit i = `DIN[4i+3:4i]`, zero-extended.
  - Decimal mode: SHIFT lasts `BIN_W` cycles of add-3/shift over a BCD register of 4·`N_DIGITS`+4 bits. The extra top digit detects overflow.
  - DONE writes the pending result, then returns to IDLE.
  - A new start can never arrive before DONE, because `DIV` > `BIN_W`+2.
- **Overflow**:
  - Decimal: value ≥ 10^`N_DIGITS`.
  - Hex: any `DIN` bit at or above 4·`N_DIGITS` is set.
  - On overflow, every digit shows dash (`SEG`=0111111), `DP` is off, and `OVF`=1 for the frame.
- **Leading-zero blanking**: with `BLANK_LZ`=1, every zero digit above the most significant nonzero digit shows blank (1111111). Digit 0 is always shown.
- **Glyphs**:
  - Digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Hex letters A–F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- **Outputs on `tick`**: registered as `AN` = all ones except bit `d_next`, `SEG` = glyph of buffer[`d_next`], `DP` = ~mask[`d_next`].
  - On a frame tick, `d_next`=0 uses the buffer committed in that same cycle.

## Timing
- **Reset values** (asynchronous, `RST_N`=0):
  - `AN`=all ones, `SEG`=1111111, `DP`=1, `OVF`=0.
  - `d`=`N_DIGITS`-1, so the first tick is a frame tick. Slot counter is 0.
  - Converter is IDLE; buffer and pending result are all zeros, not blanked.
- **Scan timing**: digit period = `DIV` cycles; frame = `N_DIGITS`·`DIV` cycles. Outputs change only in the cycle after a `tick`.
- **Latency**: inputs sampled at frame tick k appear on digit 0 one cycle after frame tick k+1, i.e. `N_DIGITS`·`DIV`+1 cycles later.
- **Input changes outside frame ticks** are ignored: no tearing.
- **First frame after reset** displays the reset buffer, which shows 0 on every digit. With the default `DIV`, the first frame tick arrives after `DIV` cycles.
- **Reset mid-conversion** aborts the conversion, returns to the reset values and discards the pending result.
- **Conversion length** is fixed regardless of `DIN`: `BIN_W`+2 cycles in decimal, 3 in hex.

## Structure
- **Package `ssd_pkg`**:
  - `seg_glyph` function mapping 4 bits to 7 bits.
  - Constants `SEG_BLANK`=1111111 and `SEG_DASH`=0111111.
  - Converter state enum `conv_state_t`.
- **Sub-module `ssd_bin2bcd_seq`**: the decimal/hex converter FSM.
  - Parameters `BIN_W`, `N_DIGITS`.
  - Ports `start`, `bin`, `hex`; outputs `done` (1-cycle pulse), `digits`, `ovf`.
- **Top level** holds the slot counter, digit index, capture and pending registers, blanking and output registers.

## Test plan
1. Defaults, `DIN`=1234, `HEX_MODE`=0, `BLANK_LZ`=0 → from the second frame, `AN` cycles 1110/1101/1011/0111 with `SEG` 0011001/0110000/0100100/1111001; `OVF`=0.
2. `DIN`=7, `BLANK_LZ`=1 → digit 0 shows 1111000, digits 1–3 show 1111111. With `DIN`=0, digit 0 shows 1000000.
3. `BIN_W`=14, `DIN`=10000 → all digits show 0111111, `OVF`=1. Then `DIN`=9999 → all digits 0010000 and `OVF`=0 one frame later.
4. `HEX_MODE`=1, `DIN`=0x7FF, `DP_IN`=0100 → digits 0–3 show 0001110, 0001110, 1111000, 1000000; `DP`=0 only while `AN`=1011.
5. Toggle `DIN` 1111↔2222 every `DIV`/3 cycles within a frame → each displayed frame is entirely the value sampled at its preceding frame tick; no mixed frame.
6. Assert `RST_N` low during the SHIFT state → immediately `AN`=1111, `SEG`=1111111, `DP`=1, `OVF`=0. After release, the first frame shows 0000, and the next frame shows the newly sampled `DIN`.
